// File: rtl/sha256_block_engine.sv
// sha256_block_engine: hashes one fixed-length message (NL bytes, padded
// internally to one 512-bit block) with SHA-256. The engine loads on an enable
// pulse, runs one compression round per clock, then adds the working state
// into the initial hash values. It presents the digest together with a
// one-cycle ready pulse.
module sha256_block_engine #(
    parameter int NL = 3,
    parameter int NK = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    data [NL],
    input  logic          enable,
    output logic [NK-1:0] hash,
    output logic          ready
);

    // The padded message must fit in a single block.
    generate
        if ((NL < 1) || (NL > 55)) begin : g_nl_check
            $error("sha256_block_engine: NL must be in 1..55");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [63:0] BIT_LEN = 64'(NL * 8);

    localparam logic [31:0] H_INIT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Round functions, written as fixed rotations so they reduce to wiring.
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    state_t        state_reg;
    state_t        state_next;
    logic          load;
    logic          do_round;
    logic          do_final;
    logic [5:0]    t_reg;
    logic [31:0]   w_reg    [16];   // w_reg[0] always holds W[t]
    logic [31:0]   work_reg [8];    // a..h
    logic [7:0]    block    [64];
    logic [31:0]   block_words [16];
    logic [31:0]   w_new;
    logic [31:0]   t1;
    logic [31:0]   t2;
    logic [NK-1:0] hash_next;

    // Build the padded block from the message bytes and the fixed bit length.
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            block[i] = 8'h00;
        end
        for (int i = 0; i < NL; i++) begin
            block[i] = data[i];
        end
        block[NL] = 8'h80;
        for (int i = 0; i < 8; i++) begin
            block[56 + i] = BIT_LEN[63 - 8*i -: 8];
        end
    end

    // Pack the padded bytes big-endian into the sixteen initial schedule words,
    // and form the final digest words from the working state.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_block_words
            assign block_words[gi] = {block[4*gi], block[4*gi + 1],
                                      block[4*gi + 2], block[4*gi + 3]};
        end
        for (gi = 0; gi < 8; gi++) begin : g_digest
            assign hash_next[NK - 1 - 32*gi -: 32] = H_INIT[gi] + work_reg[gi];
        end
    endgenerate

    // One compression round plus the next schedule word, all mod 2^32.
    always_comb begin
        t1 = work_reg[7] + big_sigma1(work_reg[4])
           + ((work_reg[4] & work_reg[5]) ^ (~work_reg[4] & work_reg[6]))
           + K_ROM[t_reg] + w_reg[0];
        t2 = big_sigma0(work_reg[0])
           + ((work_reg[0] & work_reg[1]) ^ (work_reg[0] & work_reg[2])
              ^ (work_reg[1] & work_reg[2]));
        w_new = small_sigma1(w_reg[14]) + w_reg[9]
              + small_sigma0(w_reg[1]) + w_reg[0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and per-state datapath strobes.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        do_round   = 1'b0;
        do_final   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    load       = 1'b1;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                do_round = 1'b1;
                if (t_reg == 6'd63) begin
                    state_next = FINAL;
                end
            end
            FINAL: begin
                do_final   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load the block, run the rounds, and publish the digest.
    always_ff @(posedge clk) begin
        if (!rst) begin
            t_reg <= 6'd0;
            hash  <= '0;
            ready <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                w_reg[i] <= 32'd0;
            end
            for (int i = 0; i < 8; i++) begin
                work_reg[i] <= 32'd0;
            end
        end else begin
            ready <= 1'b0;
            if (load) begin
                t_reg <= 6'd0;
                for (int i = 0; i < 16; i++) begin
                    w_reg[i] <= block_words[i];
                end
                for (int i = 0; i < 8; i++) begin
                    work_reg[i] <= H_INIT[i];
                end
            end else if (do_round) begin
                t_reg <= t_reg + 6'd1;
                for (int i = 0; i < 15; i++) begin
                    w_reg[i] <= w_reg[i + 1];
                end
                w_reg[15]   <= w_new;
                work_reg[0] <= t1 + t2;
                work_reg[1] <= work_reg[0];
                work_reg[2] <= work_reg[1];
                work_reg[3] <= work_reg[2];
                work_reg[4] <= work_reg[3] + t1;
                work_reg[5] <= work_reg[4];
                work_reg[6] <= work_reg[5];
                work_reg[7] <= work_reg[6];
            end else if (do_final) begin
                hash  <= hash_next;
                ready <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sha256_block_engine.md
Name: sha256_block_engine

Overview:
- Single-block SHA-256 hashing engine. It is the responder side of the Data/Enable/Hash/Ready hash interface.
- Accepts a fixed-length message of NL bytes on an enable pulse and pads it internally to one 512-bit block.
- Runs 64 compression rounds, one per cycle, then presents the 256-bit digest with a one-cycle ready pulse.
- Sits behind the stimulus/checker logic of the hash test environment and behind any future host-side block feeder.

Parameters:
- NL, 3, message length in bytes; legal range 1..55 so the padded message fits one block; out-of-range values are a configuration error.
- NK, 256, digest width in bits; fixed at 256.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- data  input  NL x 8 (unpacked byte array, index 0 first)  message bytes; byte 0 is the most significant byte of W0.
- enable  input  1  start request; sampled on the rising edge of clk.
- hash  output  NK  digest; H0 is in bits [255:224].
- ready  output  1  one-cycle pulse when hash is updated.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, ready=0, hash=0, round counter=0, working registers cleared.
  - Reset mid-operation aborts the hash with no ready pulse and no hash update.
- States:
  - IDLE: waits for enable.
  - ROUND: runs rounds 0..63.
  - FINAL: adds the working state into the initial hash values.
- Edge E, IDLE with enable==1: load the padded block into a 16-word W window:
  - bytes 0..NL-1 = data;
  - byte NL = 0x80;
  - zeros through byte 55;
  - bytes 56..63 = NL*8 as a 64-bit big-endian value.
  - Also at edge E: a..h <= standard SHA-256 initial H0..H7, t <= 0, go to ROUND.
- Edges E+1 .. E+64 (ROUND): one standard SHA-256 round per edge using K[t] and W[t].
  - W window shifts each round; the new word is sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16].
  - All arithmetic is mod 2^32.
  - At t==63, go to FINAL.
- Edge E+65 (FINAL):
  - hash <= {H0+a, ..., H7+h}, each sum mod 2^32;
  - ready <= 1; state <= IDLE.
- Edge E+66: ready <= 0, unless a new completion occurs at that same edge (impossible given the latency).
- Latency: ready is high in the cycle following edge E+65, i.e. 65 cycles after the enable sample. Throughput is one message per 66 cycles minimum.
- enable while state!=IDLE: ignored; no queuing, no effect on the current hash.
- enable held high: a new operation starts at each edge where state==IDLE.
  - The edge that raises ready already returns to IDLE, so the next edge may restart.
  - Data is sampled only at the load edge; changes afterwards have no effect.
- hash holds its value between completions; it is updated only at FINAL.
- ready is never high for more than one consecutive cycle.
- The K table is a 64-entry constant ROM, indexed combinationally by t.

Test Plan:
- NL=3, data="abc" (61 62 63), one enable pulse -> ready pulses exactly 65 cycles later; hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- NL=3, data="abc"; a second enable at cycle 10 with data="xyz" -> ignored; exactly one ready pulse, with the "abc" digest above; no further pulse.
- NL=3, "abc" hashed, then enable with data="abd" in the cycle after ready drops -> second ready 65 cycles later; hash differs from the "abc" digest and matches the reference model; hash keeps the "abc" digest until then.
- NL=3, start "abc", assert rst=0 at cycle 30 for one cycle -> ready never pulses; hash=0.
  - Restarting "abc" afterwards yields the correct digest after 65 cycles.
- NL=55, data = 55 x 'a' (0x61) -> hash = 9f4390f8d30c2dd92ec9f095b65e2b9ae9b0a925a5258e241c9f1e910f734318.
  - Exercises the padding boundary: 0x80 at byte 55, length 0x1b8.
- enable held high continuously with NL=3 "abc" -> ready pulses every 66 cycles; each hash equals the "abc" digest.
